// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: debug run/step/halt FSM with load-use stall, jump flush and activity counters.
module pipeline_ctrl #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int COUNT_WIDTH    = 32,
    parameter int STALL_WIDTH    = 16
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_run,
    input  logic                      i_step,
    input  logic                      i_id_ex_mem_to_reg,
    input  logic [REG_ADDR_WIDTH-1:0] i_id_ex_rt,
    input  logic [REG_ADDR_WIDTH-1:0] i_if_id_rs,
    input  logic [REG_ADDR_WIDTH-1:0] i_if_id_rt,
    input  logic                      i_jump_taken,
    input  logic                      i_halt_wb,
    output logic                      o_pc_enable,
    output logic                      o_if_id_enable,
    output logic                      o_id_ex_enable,
    output logic                      o_ex_mem_enable,
    output logic                      o_mem_wb_enable,
    output logic                      o_if_id_flush,
    output logic                      o_id_ex_flush,
    output logic [1:0]                o_state,
    output logic                      o_halted,
    output logic [COUNT_WIDTH-1:0]    o_cycle_count,
    output logic [STALL_WIDTH-1:0]    o_stall_count
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, STEP = 2'b10, HALTED = 2'b11} state_t;

    state_t                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] cycle_q, cycle_d;
    logic [STALL_WIDTH-1:0] stall_q, stall_d;
    logic                   active, stall;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q <= IDLE;
            cycle_q <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cycle_q <= cycle_d;
            stall_q <= stall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = i_run ? RUN : (i_step ? STEP : IDLE);
            RUN:     state_d = i_halt_wb ? HALTED : RUN;
            STEP:    state_d = i_halt_wb ? HALTED : IDLE;
            default: state_d = HALTED;
        endcase
    end

    always_comb begin
        active  = (state_q == RUN) || (state_q == STEP);
        stall   = active && i_id_ex_mem_to_reg && (i_id_ex_rt != '0) &&
                  ((i_id_ex_rt == i_if_id_rs) || (i_id_ex_rt == i_if_id_rt));
        cycle_d = (active && !(&cycle_q)) ? cycle_q + COUNT_WIDTH'(1) : cycle_q;
        stall_d = (stall && !(&stall_q)) ? stall_q + STALL_WIDTH'(1) : stall_q;
    end

    // A stall freezes the front end and bubbles ID/EX; it also suppresses the jump flush.
    assign o_pc_enable     = active && !stall;
    assign o_if_id_enable  = active && !stall;
    assign o_id_ex_enable  = active;
    assign o_ex_mem_enable = active;
    assign o_mem_wb_enable = active;
    assign o_if_id_flush   = active && !stall && i_jump_taken;
    assign o_id_ex_flush   = stall;
    assign o_state         = state_q;
    assign o_halted        = (state_q == HALTED);
    assign o_cycle_count   = cycle_q;
    assign o_stall_count   = stall_q;
endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameters SHALL be: REG_ADDR_WIDTH, default 5, register-index width; COUNT_WIDTH, default 32, cycle-counter width; STALL_WIDTH, default 16, stall-counter width.
REQ-002 i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 i_reset  input  1  reset, synchronous, active-low (0 = reset).
REQ-004 i_run  input  1  debug request: continuous execution; level, sampled each cycle.
REQ-005 i_step  input  1  debug request: execute one cycle; level, sampled each cycle.
REQ-006 i_id_ex_mem_to_reg  input  1  instruction in ID/EX stage is a load.
REQ-007 i_id_ex_rt  input  REG_ADDR_WIDTH  load destination register held in ID/EX stage.
REQ-008 i_if_id_rs, i_if_id_rt  input  REG_ADDR_WIDTH each  source registers of the instruction in IF/ID stage.
REQ-009 i_jump_taken  input  1  control transfer resolved in decode this cycle.
REQ-010 i_halt_wb  input  1  halt instruction has reached write-back.
REQ-011 o_pc_enable, o_if_id_enable, o_id_ex_enable, o_ex_mem_enable, o_mem_wb_enable  output  1 each  stage-register enables.
REQ-012 o_if_id_flush, o_id_ex_flush  output  1 each  stage-register flushes (insert bubble).
REQ-013 o_state  output  2  current state encoding; o_halted  output  1  state is HALTED.
REQ-014 o_cycle_count  output  COUNT_WIDTH  active-cycle counter; o_stall_count  output  STALL_WIDTH  load-use stall counter.

Function
REQ-015 State machine SHALL have states IDLE=2'b00, RUN=2'b01, STEP=2'b10, HALTED=2'b11, registered.
REQ-016 IDLE: i_run=1 -> RUN; else i_step=1 -> STEP; else stay (i_run has priority over i_step).
REQ-017 RUN: i_halt_wb=1 -> HALTED; else stay (i_run/i_step ignored).
REQ-018 STEP: i_halt_wb=1 -> HALTED; else -> IDLE unconditionally after exactly one cycle.
REQ-019 HALTED: SHALL remain until reset; all requests ignored.
REQ-020 "Active" SHALL mean state is RUN or STEP; all outputs below are combinational from state and current inputs.
REQ-021 Not active: all five enables 0, both flushes 0.
REQ-022 Load-use stall SHALL be: active AND i_id_ex_mem_to_reg AND i_id_ex_rt != 0 AND (i_id_ex_rt == i_if_id_rs OR i_id_ex_rt == i_if_id_rt).
REQ-023 Active with stall: o_pc_enable=0, o_if_id_enable=0, o_id_ex_flush=1, o_if_id_flush=0, ID/EX, EX/MEM, MEM/WB enables 1.
REQ-024 Active, no stall, i_jump_taken=1: all enables 1, o_if_id_flush=1, o_id_ex_flush=0.
REQ-025 Stall and i_jump_taken simultaneous: stall SHALL win (REQ-023 outputs, no IF/ID flush); jump is re-evaluated next cycle.
REQ-026 Active, no stall, no jump: all enables 1, both flushes 0.
REQ-027 Halt cycle (active with i_halt_wb=1): outputs per REQ-023..026 that cycle; enables drop to 0 from next cycle.
REQ-028 o_cycle_count SHALL increment by 1 each active cycle (including stall cycles), saturating at all-ones.
REQ-029 o_stall_count SHALL increment by 1 each cycle REQ-022 holds, saturating at all-ones.
REQ-030 Counters SHALL hold in IDLE and HALTED.
REQ-031 o_halted = (state == HALTED); o_state = state register.

Reset
REQ-032 i_reset=0 at a rising edge SHALL set state IDLE, both counters 0; takes priority over every other input, including mid-RUN and in HALTED.
REQ-033 During and after reset until a request: all enables 0, flushes 0, o_halted 0, o_state 2'b00.

Verification
REQ-034 Reset, then i_step=1 held 3 cycles -> states STEP, IDLE, STEP; enables high only in the STEP cycles; o_cycle_count=2.
REQ-035 RUN, ID/EX load rt=5, IF/ID rs=5 -> o_pc_enable=0, o_if_id_enable=0, o_id_ex_flush=1; o_stall_count 0->1; rt=0 case -> no stall.
REQ-036 RUN, i_jump_taken=1 with no hazard -> o_if_id_flush=1, all enables 1; with concurrent hazard -> stall outputs, o_if_id_flush=0.
REQ-037 RUN, i_halt_wb=1 one cycle -> next cycle o_state=2'b11, o_halted=1, enables 0; i_run=1 afterwards -> no change; i_reset=0 -> IDLE, counters 0.
REQ-038 i_run and i_step both 1 in IDLE -> RUN; preload counters near all-ones (run 2^STALL_WIDTH+ stall cycles, reduced width) -> counters saturate, no wrap.
